spram_bw: RTL and testbench
===========================

SPRAM_BW -- requirements
Module: spram_bw

Interface
REQ-001 Parameter MemoryInitFile, default "none"; hex init file, "none" = contents undefined at start.
REQ-002 Parameter AddrBusWidth, default 32; word-address width.
REQ-003 Parameter DataBusWidth, default 32; word width in bits.
REQ-004 Parameter ByteWidth, default 8; width of one write-enable lane.
REQ-005 Parameter MemSizeWords, default 0; depth in words, 0 = 2**AddrBusWidth.
REQ-006 Parameter ReadLatency, default 1; clk cycles from read request to data, legal 1..4.
REQ-007 Parameter WriteMode, default READ_FIRST; collision mode READ_FIRST / WRITE_FIRST / NO_CHANGE (package enum).
REQ-008 clk  in  1  sole clock, all state updates on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 re  in  1  read request for addr this cycle.
REQ-011 addr  in  AddrBusWidth  word address, shared by read and write.
REQ-012 we  in  DataBusWidth/ByteWidth  per-lane write enables, bit i covers w_data lane i.
REQ-013 w_data  in  DataBusWidth  write data.
REQ-014 r_data  out  DataBusWidth  read data, registered.
REQ-015 r_valid  out  1  one-cycle pulse, r_data carries a new read result.

Function
REQ-016 Depth SHALL be MemSizeWords if >0, else 2**AddrBusWidth; width DataBusWidth.
REQ-017 Elaboration SHALL fail if DataBusWidth%ByteWidth!=0, ReadLatency outside 1..4, or depth>2**AddrBusWidth.
REQ-018 Write: at edge with rst=0, every lane i with we[i]=1 SHALL update that lane of mem[addr]; lanes with we[i]=0 unchanged.
REQ-019 Read: request at edge N with re=1 SHALL present data on r_data and r_valid=1 at edge N+ReadLatency; pipeline accepts one request per cycle, no stalls.
REQ-020 r_data SHALL hold its last value in cycles where r_valid=0.
REQ-021 Collision (re=1, we!=0, same cycle), READ_FIRST: result = word before write.
REQ-022 Collision, WRITE_FIRST: result = merged word (enabled lanes from w_data, others old contents).
REQ-023 Collision, NO_CHANGE: write performed, read dropped; no r_valid for that slot, r_data unchanged.
REQ-024 Write-only cycles (re=0) SHALL never pulse r_valid or change r_data.
REQ-025 addr >= depth: write ignored; read returns all-zero data with r_valid=1 at normal latency.
REQ-026 Read of a word written at an earlier edge SHALL return the written data (no stale forwarding hazard across cycles).
REQ-027 Memory init from MemoryInitFile at elaboration when not "none".

Reset
REQ-028 rst=1 SHALL clear r_data to 0 and all read-pipeline valid bits to 0 at the next edge; in-flight reads dropped, no r_valid for them.
REQ-029 Memory contents SHALL NOT be reset; writes and reads presented while rst=1 SHALL be ignored.
REQ-030 First accepted request is at the first edge with rst=0; latency counted from there.

Structure
REQ-031 Package spram_pkg SHALL hold the write_mode_e enum and the ReadLatency max constant (4).
REQ-032 Sub-module spram_rd_pipe SHALL implement the (ReadLatency-1)-stage data/valid delay line with sync reset; the array and first read register stay in spram_bw.
REQ-033 Array coded for block-RAM inference: one read and one write port on same address, no reset on the array.

Verification
REQ-034 Byte lanes: DataBusWidth=32; write 0xDEADBEEF, then we=4'b0101 data 0x11223344 -> read gives 0xDE22BE44.
REQ-035 Latency: ReadLatency=3, re on 4 consecutive cycles to addr 0..3 -> r_valid high exactly at edges N+3..N+6, data in order.
REQ-036 Collision: mem[5]=0xAAAAAAAA, re=1 we=4'hF data 0x55555555 at addr 5 -> READ_FIRST 0xAAAAAAAA; WRITE_FIRST 0x55555555; NO_CHANGE no r_valid, next read 0x55555555.
REQ-037 Reset mid-flight: ReadLatency=4, 2 reads issued, rst pulsed 1 cycle -> r_valid never asserts for them, r_data=0, memory retains prior writes.
REQ-038 Out of range: MemSizeWords=16, write 0x1234 at addr 20, read addr 20 -> 0 with r_valid; addr 4 (=20 mod 16) unchanged.

Source files
------------

// File: rtl/spram_bw_pkg.sv
// Shared types and limits for the byte-write single-port RAM.
package spram_pkg;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } write_mode_e;

  localparam int MaxReadLatency = 4;

endpackage

// File: rtl/spram_rd_pipe.sv
// Read-result delay line: Stages registers of data + valid behind the RAM output register.
module spram_rd_pipe #(
  parameter int Width  = 32,
  parameter int Stages = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  output logic [Width-1:0] out_data
);

  if (Stages == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [Stages:1]            vld_pipe;
    logic [Stages:1][Width-1:0] dat_pipe;

    // Data registers only load behind a valid bit, so the output holds between results.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        vld_pipe[1] <= in_valid;
        if (in_valid) dat_pipe[1] <= in_data;
        for (int k = 2; k <= Stages; k++) begin
          vld_pipe[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
        end
      end
    end

    assign out_valid = vld_pipe[Stages];
    assign out_data  = dat_pipe[Stages];
  end

endmodule

// File: rtl/spram_bw.sv
// Single-port RAM with per-lane write enables, configurable read latency and collision mode.
module spram_bw
  import spram_pkg::*;
#(
  parameter string       MemoryInitFile = "none",
  parameter int          AddrBusWidth   = 32,
  parameter int          DataBusWidth   = 32,
  parameter int          ByteWidth      = 8,
  parameter int          MemSizeWords   = 0,
  parameter int          ReadLatency    = 1,
  parameter write_mode_e WriteMode      = READ_FIRST
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                re,
  input  logic [AddrBusWidth-1:0]             addr,
  input  logic [DataBusWidth/ByteWidth-1:0]   we,
  input  logic [DataBusWidth-1:0]             w_data,
  output logic [DataBusWidth-1:0]             r_data,
  output logic                                r_valid
);

  localparam int              NumLanes  = DataBusWidth / ByteWidth;
  localparam longint unsigned AddrSpace = 64'd1 << AddrBusWidth;
  localparam longint unsigned Depth     = (MemSizeWords > 0) ? 64'(MemSizeWords) : AddrSpace;
  localparam int              IdxW      = (Depth > 1) ? $clog2(Depth) : 1;

  if (DataBusWidth % ByteWidth != 0) begin : g_bad_lanes
    $error("spram_bw: DataBusWidth must be a multiple of ByteWidth");
  end
  if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : g_bad_latency
    $error("spram_bw: ReadLatency must be 1..%0d", MaxReadLatency);
  end
  if (64'(MemSizeWords) > AddrSpace) begin : g_bad_depth
    $error("spram_bw: MemSizeWords exceeds address space");
  end

  logic [DataBusWidth-1:0] mem [0:Depth-1];

  logic [IdxW-1:0]         idx;
  logic                    in_range;
  logic                    wr_any;
  logic                    rd_take;
  logic [DataBusWidth-1:0] merged;
  logic [DataBusWidth-1:0] rd_q;
  logic                    rd_v;

  assign idx      = addr[IdxW-1:0];
  assign in_range = 64'(addr) < Depth;
  assign wr_any   = |we;
  // NO_CHANGE drops the read half of a colliding access.
  assign rd_take  = re && !(WriteMode == NO_CHANGE && wr_any);

  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < NumLanes; i++)
      if (we[i]) merged[i*ByteWidth +: ByteWidth] = w_data[i*ByteWidth +: ByteWidth];
  end

  always_ff @(posedge clk) begin
    if (!rst && in_range)
      for (int i = 0; i < NumLanes; i++)
        if (we[i]) mem[idx][i*ByteWidth +: ByteWidth] <= w_data[i*ByteWidth +: ByteWidth];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      rd_v <= 1'b0;
    end else begin
      rd_v <= rd_take;
      if (rd_take) begin
        if (!in_range)                            rd_q <= '0;
        else if (WriteMode == WRITE_FIRST && wr_any) rd_q <= merged;
        else                                      rd_q <= mem[idx];
      end
    end
  end

  spram_rd_pipe #(
    .Width  (DataBusWidth),
    .Stages (ReadLatency - 1)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_v),
    .in_data   (rd_q),
    .out_valid (r_valid),
    .out_data  (r_data)
  );

endmodule

// File: tb/tb_spram_bw.sv
// Directed bench: three spram_bw instances covering latency 1/3/4 and each collision mode.
module tb_spram_bw;
  import spram_pkg::*;

  logic        clk;
  logic        rst;
  logic        re     [3];
  logic [7:0]  addr   [3];
  logic [3:0]  we     [3];
  logic [31:0] w_data [3];
  logic [31:0] r_data [3];
  logic        r_valid[3];

  int checks   = 0;
  int failures = 0;

  spram_bw #(.AddrBusWidth(8), .MemSizeWords(16), .ReadLatency(1), .WriteMode(READ_FIRST)) u0 (
    .clk(clk), .rst(rst), .re(re[0]), .addr(addr[0]), .we(we[0]), .w_data(w_data[0]),
    .r_data(r_data[0]), .r_valid(r_valid[0]));
  spram_bw #(.AddrBusWidth(8), .MemSizeWords(16), .ReadLatency(3), .WriteMode(WRITE_FIRST)) u1 (
    .clk(clk), .rst(rst), .re(re[1]), .addr(addr[1]), .we(we[1]), .w_data(w_data[1]),
    .r_data(r_data[1]), .r_valid(r_valid[1]));
  spram_bw #(.AddrBusWidth(8), .MemSizeWords(16), .ReadLatency(4), .WriteMode(NO_CHANGE)) u2 (
    .clk(clk), .rst(rst), .re(re[2]), .addr(addr[2]), .we(we[2]), .w_data(w_data[2]),
    .r_data(r_data[2]), .r_valid(r_valid[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int u, input logic r, input logic [7:0] a,
                       input logic [3:0] w, input logic [31:0] d);
    re[u] = r; addr[u] = a; we[u] = w; w_data[u] = d;
  endtask

  task automatic idle_all;
    for (int u = 0; u < 3; u++) drive(u, 1'b0, 8'd0, 4'd0, 32'd0);
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    tick(); tick();
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst_rdata_u%0d", u), r_data[u], 32'd0);
      chk($sformatf("rst_rvalid_u%0d", u), 32'(r_valid[u]), 32'd0);
    end
    rst = 1'b0;

    // u0: latency 1, READ_FIRST
    drive(0, 1'b0, 8'd1, 4'hF, 32'hDEADBEEF); tick();
    chk("wonly_valid", 32'(r_valid[0]), 32'd0);
    chk("wonly_data", r_data[0], 32'd0);
    drive(0, 1'b0, 8'd1, 4'b0101, 32'h11223344); tick();
    drive(0, 1'b1, 8'd1, 4'h0, 32'd0); tick();
    chk("lanes_valid", 32'(r_valid[0]), 32'd1);
    chk("lanes_data", r_data[0], 32'hDE22BE44);
    drive(0, 1'b0, 8'd0, 4'h0, 32'd0); tick();
    chk("hold_valid", 32'(r_valid[0]), 32'd0);
    chk("hold_data", r_data[0], 32'hDE22BE44);
    drive(0, 1'b0, 8'd5, 4'hF, 32'hAAAAAAAA); tick();
    drive(0, 1'b1, 8'd5, 4'hF, 32'h55555555); tick();
    chk("rf_valid", 32'(r_valid[0]), 32'd1);
    chk("rf_data", r_data[0], 32'hAAAAAAAA);
    drive(0, 1'b1, 8'd5, 4'h0, 32'd0); tick();
    chk("rf_after", r_data[0], 32'h55555555);
    drive(0, 1'b0, 8'd4, 4'hF, 32'h0000CAFE); tick();
    drive(0, 1'b0, 8'd20, 4'hF, 32'h00001234); tick();
    drive(0, 1'b1, 8'd20, 4'h0, 32'd0); tick();
    chk("oor_valid", 32'(r_valid[0]), 32'd1);
    chk("oor_data", r_data[0], 32'd0);
    drive(0, 1'b1, 8'd4, 4'h0, 32'd0); tick();
    chk("oor_alias", r_data[0], 32'h0000CAFE);
    idle_all();

    // u1: latency 3, WRITE_FIRST
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b0, 8'(i), 4'hF, 32'h100 + 32'(i)); tick();
    end
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1, 1'b1, 8'(c), 4'h0, 32'd0);
      else       drive(1, 1'b0, 8'd0, 4'h0, 32'd0);
      tick();
      chk($sformatf("lat_valid_c%0d", c), 32'(r_valid[1]), (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 5) chk($sformatf("lat_data_c%0d", c), r_data[1], 32'h100 + 32'(c - 2));
    end
    chk("lat_hold", r_data[1], 32'h103);
    drive(1, 1'b0, 8'd5, 4'hF, 32'hAAAAAAAA); tick();
    drive(1, 1'b1, 8'd5, 4'hF, 32'h55555555); tick();
    idle_all(); tick(); tick();
    chk("wf_valid", 32'(r_valid[1]), 32'd1);
    chk("wf_data", r_data[1], 32'h55555555);
    drive(1, 1'b1, 8'd5, 4'b0011, 32'h00001111); tick();
    idle_all(); tick(); tick();
    chk("wf_merge", r_data[1], 32'h55551111);

    // u2: latency 4, NO_CHANGE, then reset with reads in flight
    drive(2, 1'b0, 8'd5, 4'hF, 32'hAAAAAAAA); tick();
    drive(2, 1'b1, 8'd5, 4'hF, 32'h55555555); tick();
    idle_all();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("nc_novalid_k%0d", k), 32'(r_valid[2]), 32'd0);
    end
    chk("nc_data_held", r_data[2], 32'd0);
    drive(2, 1'b1, 8'd5, 4'h0, 32'd0); tick();
    idle_all(); tick(); tick(); tick();
    chk("nc_next_valid", 32'(r_valid[2]), 32'd1);
    chk("nc_next_data", r_data[2], 32'h55555555);
    drive(2, 1'b0, 8'd7, 4'hF, 32'h77777777); tick();
    drive(2, 1'b0, 8'd8, 4'hF, 32'h88888888); tick();
    drive(2, 1'b1, 8'd7, 4'h0, 32'd0); tick();
    drive(2, 1'b1, 8'd8, 4'h0, 32'd0); tick();
    rst = 1'b1;
    drive(2, 1'b1, 8'd7, 4'hF, 32'hFFFFFFFF); tick();
    rst = 1'b0;
    idle_all();
    chk("rstmid_data", r_data[2], 32'd0);
    chk("rstmid_valid", 32'(r_valid[2]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rstmid_novalid_k%0d", k), 32'(r_valid[2]), 32'd0);
    end
    drive(2, 1'b1, 8'd7, 4'h0, 32'd0); tick();
    drive(2, 1'b1, 8'd8, 4'h0, 32'd0); tick();
    idle_all(); tick(); tick();
    chk("retain7_valid", 32'(r_valid[2]), 32'd1);
    chk("retain7_data", r_data[2], 32'h77777777);
    tick();
    chk("retain8_data", r_data[2], 32'h88888888);
    tick();
    chk("retain_end_valid", 32'(r_valid[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
